// File: rtl/cpu_pkg.sv
// Shared CPU constants: datapath width, data memory depth and opcode encodings.
package cpu_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned DMEM_DEPTH = 256;

  localparam logic [3:0] LOAD = 4'b0011;
  localparam logic [3:0] NOP  = 4'b1111;

endpackage : cpu_pkg

// File: rtl/data_memory.sv
// Word-addressed MEM-stage data RAM: combinational gated read, posedge write,
// asynchronous active-low clear of the whole array.
module data_memory
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = DMEM_DEPTH
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic [XLEN-1:0] address,
  input  logic [XLEN-1:0] write_data,
  output logic [XLEN-1:0] read_data
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);

  logic [XLEN-1:0]   mem [DEPTH];
  logic [ADDR_W-1:0] idx;
  logic              in_range;

  // Upper bits must be zero; an out-of-range word never aliases into the array.
  assign idx      = address[ADDR_W-1:0];
  assign in_range = (address[XLEN-1:ADDR_W] == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[ADDR_W'(i)] <= '0;
      end
    end else if (mem_write && in_range) begin
      mem[idx] <= write_data;
    end
  end

  // Read sees the pre-edge word on a same-cycle read/write to one address.
  assign read_data = (reset && mem_read && in_range) ? mem[idx] : '0;

endmodule : data_memory

// File: tb/tb_data_memory.sv
// Scoreboard bench for data_memory: stimulus queues expected read_data values,
// a monitor process pops and compares them against the DUT.
module tb_data_memory;
  import cpu_pkg::*;

  localparam int unsigned DEPTH = DMEM_DEPTH;

  typedef struct {
    string           name;
    logic [XLEN-1:0] exp;
  } exp_t;

  logic            clk;
  logic            reset;
  logic            mem_read;
  logic            mem_write;
  logic [XLEN-1:0] address;
  logic [XLEN-1:0] write_data;
  logic [XLEN-1:0] read_data;

  int tests_run = 0;
  int tests_failed = 0;
  exp_t exp_q[$];

  data_memory #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: whenever an expectation is queued, inputs have settled; compare now.
  initial begin
    exp_t e;
    forever begin
      wait (exp_q.size() != 0);
      e = exp_q.pop_front();
      tests_run++;
      if (read_data !== e.exp) begin
        tests_failed++;
        $display("FAIL %s: read_data=0x%08h expected 0x%08h", e.name, read_data, e.exp);
      end
    end
  end

  task automatic expect_rd(input string name, input logic [XLEN-1:0] exp);
    exp_t e;
    e.name = name;
    e.exp  = exp;
    exp_q.push_back(e);
    #1;
  endtask

  task automatic write_word(input logic [XLEN-1:0] addr, input logic [XLEN-1:0] data);
    @(negedge clk);
    mem_read   = 1'b0;
    mem_write  = 1'b1;
    address    = addr;
    write_data = data;
    @(negedge clk);
    mem_write  = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [XLEN-1:0] addr,
                            input logic [XLEN-1:0] exp);
    mem_read = 1'b1;
    address  = addr;
    #1;
    expect_rd(name, exp);
  endtask

  task automatic display_all();
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (dut.mem[i] != '0) $display("mem[%0d] = %0d", i, dut.mem[i]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b0;
    mem_read   = 1'b1;
    mem_write  = 1'b0;
    address    = '0;
    write_data = '0;
    #2;
    expect_rd("reset_read_zero", 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Reset clear mid-cycle
    write_word(32'd5, 32'hDEAD_BEEF);
    read_check("pre_reset_addr5", 32'd5, 32'hDEAD_BEEF);
    reset = 1'b0;
    #1;
    expect_rd("reset_gates_read", 32'h0);
    @(negedge clk);
    reset = 1'b1;
    read_check("post_reset_addr5", 32'd5, 32'h0);

    // Write then zero-latency read; mem_read gating
    write_word(32'd10, 32'd42);
    read_check("read_addr10", 32'd10, 32'd42);
    mem_read = 1'b0;
    #1;
    expect_rd("read_disabled", 32'h0);

    // Same-cycle read/write to one address
    write_word(32'd3, 32'd7);
    mem_read   = 1'b1;
    mem_write  = 1'b1;
    address    = 32'd3;
    write_data = 32'd9;
    #1;
    expect_rd("raw_before_edge", 32'd7);
    @(posedge clk);
    #1;
    expect_rd("raw_after_edge", 32'd9);
    @(negedge clk);
    mem_write = 1'b0;

    // Out-of-range accesses
    write_word(32'd256, 32'h55);
    read_check("oob_no_alias_0", 32'd0, 32'h0);
    read_check("oob_no_alias_255", 32'd255, 32'h0);
    read_check("oob_read_256", 32'd256, 32'h0);
    read_check("oob_read_max", 32'hFFFF_FFFF, 32'h0);

    // Last in-range word
    write_word(32'd255, 32'hFFFF_FFFF);
    read_check("boundary_255", 32'd255, 32'hFFFF_FFFF);
    read_check("boundary_254", 32'd254, 32'h0);
    read_check("oob_max_after_255", 32'hFFFF_FFFF, 32'h0);

    // Writes are blocked while reset is held low
    @(negedge clk);
    reset      = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b1;
    address    = 32'd1;
    write_data = 32'd99;
    repeat (2) @(negedge clk);
    mem_write = 1'b0;
    reset     = 1'b1;
    read_check("reset_priority_addr1", 32'd1, 32'h0);
    read_check("reset_cleared_255", 32'd255, 32'h0);

    // Persistence across idle cycles
    write_word(32'd20, 32'h0000_1234);
    mem_read = 1'b0;
    address  = 32'd0;
    repeat (5) @(negedge clk);
    read_check("persist_addr20", 32'd20, 32'h0000_1234);
    read_check("other_word_addr21", 32'd21, 32'h0);

    mem_read = 1'b0;
    address  = 'x;
    #1;
    expect_rd("x_addr_read_off", 32'h0);

    // Drain the scoreboard within a bounded window
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL scoreboard_drain: %0d pending expected 0", exp_q.size());
    end

    display_all();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_data_memory
